tlb_lookup_arbiter: RTL and testbench

TLB_LOOKUP_ARBITER -- requirements
Module: tlb_lookup_arbiter

---
 rtl/tlb_lookup_arbiter_pkg.sv | 23 ++
 rtl/tlb_lookup_arbiter_rr_arb2.sv | 14 +
 rtl/tlb_lookup_arbiter.sv | 113 +++++++++++
 tb/tb_tlb_lookup_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tlb_lookup_arbiter_pkg.sv
// Shared types for the fetch/data TLB lookup arbiter: FSM states, requester IDs
// and the captured TLB result record.
package tlb_lookup_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic [2:0]  cattr;
  } tlb_res_t;

endpackage

// File: rtl/tlb_lookup_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side
// that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       lg,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = lg ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/tlb_lookup_arbiter.sv
// Shares one combinational TLB port between fetch and load/store lookups;
// results are registered and announced with a one-cycle rvalid to the owner.
module tlb_lookup_arbiter
  import tlb_lookup_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  output logic        i_ack,
  output logic        i_rvalid,
  input  logic        d_req,
  input  logic [31:0] d_vaddr,
  output logic        d_ack,
  output logic        d_rvalid,
  input  logic        flush,
  input  logic        tlb_write,
  output logic [31:0] tlb_vaddr,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_miss,
  input  logic        tlb_invalid,
  input  logic [2:0]  tlb_cattr,
  output logic [31:0] r_paddr,
  output logic        r_miss,
  output logic        r_invalid,
  output logic [2:0]  r_cattr,
  output logic [31:0] perfcnt_tlb_conflict
);

  state_e      state_q, state_d;
  req_id_e     lg_q, owner_q, gnt_id;
  logic [31:0] vaddr_q;
  tlb_res_t    res_q;
  logic [31:0] conflict_q;
  logic [1:0]  gnt;
  logic        grant_en, capture;

  rr_arb2 u_arb (
    .req   ({d_req, i_req}),
    .lg    (lg_q == REQ_DATA),
    .grant (gnt)
  );

  assign gnt_id = gnt[1] ? REQ_DATA : REQ_FETCH;
  assign i_ack  = grant_en & gnt[0];
  assign d_ack  = grant_en & gnt[1];

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: state_d = (!flush && (i_req || d_req)) ? ST_LOOKUP : ST_IDLE;
      // A TLB write lands this edge, so the lookup is simply re-run next cycle.
      ST_LOOKUP: begin
        if (flush)           state_d = ST_IDLE;
        else if (!tlb_write) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_en = 1'b0;
    capture  = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    if (resetn) begin
      unique case (state_q)
        ST_IDLE:   grant_en = !flush;
        ST_LOOKUP: capture  = !flush && !tlb_write;
        ST_RESP: begin
          grant_en = !flush;
          i_rvalid = !flush && (owner_q == REQ_FETCH);
          d_rvalid = !flush && (owner_q == REQ_DATA);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lg_q    <= REQ_DATA;
      owner_q <= REQ_FETCH;
      vaddr_q <= '0;
      res_q   <= '0;
    end else begin
      if (i_ack || d_ack) begin
        lg_q    <= gnt_id;
        owner_q <= gnt_id;
        vaddr_q <= gnt[1] ? d_vaddr : i_vaddr;
      end
      if (capture) res_q <= '{paddr: tlb_paddr, miss: tlb_miss, invalid: tlb_invalid, cattr: tlb_cattr};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) conflict_q <= '0;
    else if ((i_req && !i_ack) || (d_req && !d_ack)) conflict_q <= conflict_q + 32'd1;
  end

  assign tlb_vaddr            = vaddr_q;
  assign r_paddr              = res_q.paddr;
  assign r_miss               = res_q.miss;
  assign r_invalid            = res_q.invalid;
  assign r_cattr              = res_q.cattr;
  assign perfcnt_tlb_conflict = conflict_q;

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Bench for tlb_lookup_arbiter: directed vector table, corner sequences, and
// random traffic against a transaction-level reference model.
module tb_tlb_lookup_arbiter;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, flush = 1'b0, tlb_write = 1'b0;
  logic [31:0] i_vaddr = 32'h0040_1000, d_vaddr = 32'h0080_2000;
  logic        i_ack, d_ack, i_rvalid, d_rvalid;
  logic [31:0] tlb_vaddr, tlb_paddr, r_paddr, perfcnt;
  logic        tlb_miss, tlb_invalid, r_miss, r_invalid;
  logic [2:0]  tlb_cattr, r_cattr;

  always #5 clk = ~clk;

  tlb_lookup_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_vaddr(i_vaddr), .i_ack(i_ack), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_vaddr(d_vaddr), .d_ack(d_ack), .d_rvalid(d_rvalid),
    .flush(flush), .tlb_write(tlb_write), .tlb_vaddr(tlb_vaddr),
    .tlb_paddr(tlb_paddr), .tlb_miss(tlb_miss), .tlb_invalid(tlb_invalid),
    .tlb_cattr(tlb_cattr), .r_paddr(r_paddr), .r_miss(r_miss),
    .r_invalid(r_invalid), .r_cattr(r_cattr), .perfcnt_tlb_conflict(perfcnt)
  );

  // Toy TLB: a simple mapping whose key changes on every TLB write.
  logic [31:0] tkey = 32'h1f80_0000;
  logic        tmiss = 1'b0, tinv = 1'b0;
  logic [2:0]  tcat = 3'd3;
  assign tlb_paddr   = tlb_vaddr ^ tkey;
  assign tlb_miss    = tmiss ^ tlb_vaddr[3];
  assign tlb_invalid = tinv ^ tlb_vaddr[4];
  assign tlb_cattr   = tcat ^ tlb_vaddr[7:5];

  int checks = 0, errors = 0;
  bit m_en = 1'b0;

  // Reference model: one lookup outstanding at most, result due the cycle after it completes.
  bit          m_busy = 0, m_resp = 0, m_own = 0, m_lg = 1;
  logic [31:0] m_va = '0, m_pa = '0, m_cnt = '0;
  logic        m_miss = 0, m_inv = 0;
  logic [2:0]  m_cat = '0;
  bit          e_iack, e_dack, e_irv, e_drv;
  logic        s_iack, s_dack, s_irv, s_drv;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_comb();
    e_iack = 0; e_dack = 0; e_irv = 0; e_drv = 0;
    if (resetn) begin
      if (!m_busy && !flush && (i_req || d_req)) begin
        if (i_req && d_req) begin
          if (m_lg) e_iack = 1; else e_dack = 1;
        end else begin
          e_iack = i_req; e_dack = d_req;
        end
      end
      if (m_resp && !flush) begin
        if (m_own) e_drv = 1; else e_irv = 1;
      end
    end
  endtask

  task automatic model_seq();
    if (!resetn) begin
      m_busy = 0; m_resp = 0; m_lg = 1; m_own = 0;
      m_va = '0; m_pa = '0; m_miss = 0; m_inv = 0; m_cat = '0; m_cnt = '0;
    end else begin
      if ((i_req && !e_iack) || (d_req && !e_dack)) m_cnt = m_cnt + 1;
      if (flush) begin
        m_busy = 0; m_resp = 0;
      end else if (m_busy) begin
        if (!tlb_write) begin
          m_pa = m_va ^ tkey; m_miss = tmiss ^ m_va[3];
          m_inv = tinv ^ m_va[4]; m_cat = tcat ^ m_va[7:5];
          m_busy = 0; m_resp = 1;
        end
      end else begin
        m_resp = 0;
        if (e_iack || e_dack) begin
          m_busy = 1; m_own = e_dack; m_lg = e_dack;
          m_va = e_dack ? d_vaddr : i_vaddr;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    s_iack = i_ack; s_dack = d_ack; s_irv = i_rvalid; s_drv = d_rvalid;
    model_comb();
    if (m_en) begin
      chk("i_ack", i_ack, e_iack);
      chk("d_ack", d_ack, e_dack);
      chk("i_rvalid", i_rvalid, e_irv);
      chk("d_rvalid", d_rvalid, e_drv);
      chk("tlb_vaddr", tlb_vaddr, m_va);
      chk("r_paddr", r_paddr, m_pa);
      chk("r_miss", r_miss, m_miss);
      chk("r_invalid", r_invalid, m_inv);
      chk("r_cattr", r_cattr, m_cat);
      chk("perfcnt", perfcnt, m_cnt);
    end
    @(posedge clk);
    model_seq();
    #1;
    if (tlb_write) begin
      tkey = tkey + 32'h0001_0000;
      tmiss = ~tmiss;
    end
  endtask

  typedef struct {
    bit rs, ir, dr, fl;
    bit eia, eda, eir, edr;
  } vec_t;
  vec_t tbl[16];

  initial begin
    bit bad;
    tbl[0]  = '{1,0,0,0, 0,0,0,0};  // reset
    tbl[1]  = '{0,1,0,0, 1,0,0,0};  // fetch only
    tbl[2]  = '{0,0,0,0, 0,0,0,0};
    tbl[3]  = '{0,0,0,0, 0,0,1,0};
    tbl[4]  = '{0,0,0,0, 0,0,0,0};
    tbl[5]  = '{1,0,0,0, 0,0,0,0};  // reset, then tie
    tbl[6]  = '{0,1,1,0, 1,0,0,0};
    tbl[7]  = '{0,0,1,0, 0,0,0,0};
    tbl[8]  = '{0,0,1,0, 0,1,1,0};
    tbl[9]  = '{0,0,0,0, 0,0,0,0};
    tbl[10] = '{0,0,0,0, 0,0,0,1};
    tbl[11] = '{0,0,0,0, 0,0,0,0};
    tbl[12] = '{0,0,1,1, 0,0,0,0};  // flush in idle blocks grant
    tbl[13] = '{0,0,1,0, 0,1,0,0};
    tbl[14] = '{0,0,0,0, 0,0,0,0};
    tbl[15] = '{0,0,0,0, 0,0,0,1};

    cycle();  // first edge brings the DUT out of its power-up state
    m_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      resetn = !tbl[i].rs; i_req = tbl[i].ir; d_req = tbl[i].dr; flush = tbl[i].fl;
      cycle();
      chk($sformatf("tbl[%0d].i_ack", i), s_iack, tbl[i].eia);
      chk($sformatf("tbl[%0d].d_ack", i), s_dack, tbl[i].eda);
      chk($sformatf("tbl[%0d].i_rvalid", i), s_irv, tbl[i].eir);
      chk($sformatf("tbl[%0d].d_rvalid", i), s_drv, tbl[i].edr);
      if (i == 4) begin
        chk("fetch r_paddr", r_paddr, 32'h1fc0_1000);
        chk("fetch r_cattr", r_cattr, 3'd3);
      end
      if (i == 11) chk("tie perfcnt", perfcnt, 32'd2);
    end
    resetn = 1; i_req = 0; d_req = 0; flush = 0;

    // TLB write in LOOKUP: miss before, hit after, result one cycle late
    tmiss = 1'b1;
    d_req = 1; cycle(); chk("tw d_ack", s_dack, 1);
    d_req = 0; tlb_write = 1; cycle(); chk("tw lookup rvalid", s_drv, 0);
    tlb_write = 0; cycle(); chk("tw delayed rvalid", s_drv, 0);
    cycle(); chk("tw d_rvalid", s_drv, 1);
    chk("tw r_miss", r_miss, 0);

    // flush during RESP
    i_req = 1; cycle(); chk("fl i_ack", s_iack, 1);
    i_req = 0; cycle();
    flush = 1; d_req = 1; cycle();
    chk("fl i_rvalid", s_irv, 0); chk("fl d_ack", s_dack, 0);
    flush = 0; cycle(); chk("fl idle grant", s_dack, 1);
    d_req = 0; cycle(); cycle(); chk("fl d_rvalid", s_drv, 1);

    // reset during LOOKUP
    i_req = 1; cycle(); chk("rs i_ack", s_iack, 1);
    i_req = 0; resetn = 0; cycle();
    resetn = 1;
    bad = 0;
    repeat (4) begin cycle(); if (s_irv || s_drv) bad = 1; end
    chk("rs no rvalid", bad, 0);
    chk("rs r_paddr", r_paddr, 0);
    chk("rs r_cattr", r_cattr, 0);
    i_req = 1; d_req = 1; cycle();
    chk("rs tie i_ack", s_iack, 1); chk("rs tie d_ack", s_dack, 0);
    i_req = 0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (!i_req && ($urandom_range(2) != 0)) begin i_req = 1; i_vaddr = $urandom; end
      if (!d_req && ($urandom_range(2) != 0)) begin d_req = 1; d_vaddr = $urandom; end
      flush     = ($urandom_range(15) == 0);
      tlb_write = ($urandom_range(7) == 0);
      resetn    = ($urandom_range(199) != 0);
      if ($urandom_range(63) == 0) begin tinv = $urandom; tcat = 3'($urandom); end
      cycle();
      if (s_iack) i_req = 0;
      if (s_dack) d_req = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
